// File: rtl/aes_pkg.sv
// Shared AES types, FSM state encoding and GF(2^8) helpers for the encryption
// block arbiter and its shared round transform.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } arb_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box built from the multiplicative inverse (b^254) followed by the AES affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv;
        logic [7:0] e;
        e   = 8'hfe;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gf_mul(inv, inv);
            if (e[i]) inv = gf_mul(inv, b);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/encryption_block_arbiter_if.sv
// Request/response bundle between AES sequencers (master) and the shared
// round-transform arbiter (slave).
interface encryption_block_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int BLK_W = 128
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*BLK_W-1:0] req_data;
    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_ready;
    logic [BLK_W-1:0]       rsp_data;
    logic                   busy;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/encryption_block.sv
// Combinational AES round without key addition: SubBytes, ShiftRows, MixColumns.
// Operand bytes sit LSB-first within each column word; result columns are packed row 0 first (MSB).
module encryption_block
    import aes_pkg::*;
(
    input  aes_block_t data_i,
    output aes_block_t data_o
);

    logic [7:0] col [4];

    always_comb begin
        data_o = '0;
        col    = '{default: '0};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                col[r] = sbox(data_i[32*((c + r) % 4) + 8*r +: 8]);
            end
            for (int r = 0; r < 4; r++) begin
                data_o[32*c + 8*(3 - r) +: 8] = xtime(col[r]) ^ xtime(col[(r + 1) % 4])
                                              ^ col[(r + 1) % 4] ^ col[(r + 2) % 4]
                                              ^ col[(r + 3) % 4];
            end
        end
    end

endmodule

// File: rtl/encryption_block_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr_i,
// wrapping modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o
);

    logic found;
    int   cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(ptr_i) + k) % N_REQ;
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/encryption_block_arbiter.sv
// Shares one AES round transform among N_REQ requesters, one transaction at a time,
// with registered operand and result around the combinational datapath.
module encryption_block_arbiter
    import aes_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int BLK_W = AES_BLOCK_W
) (
    input logic                        clk,
    input logic                        n_rst,
    encryption_block_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    aes_block_t       in_reg_q, in_reg_d;
    aes_block_t       out_reg_q, out_reg_d;

    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] owner_next;
    aes_block_t       enc_out;

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr_arbiter (
        .req_i   (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx)
    );

    encryption_block u_encryption_block (
        .data_i (in_reg_q),
        .data_o (enc_out)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            in_reg_q  <= '0;
            out_reg_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            in_reg_q  <= in_reg_d;
            out_reg_q <= out_reg_d;
        end
    end

    assign owner_next = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        in_reg_d  = in_reg_q;
        out_reg_d = out_reg_q;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    in_reg_d = bus.req_data[grant_idx*BLK_W +: BLK_W];
                    owner_d  = grant_idx;
                    state_d  = CALC;
                end
            end
            CALC: begin
                out_reg_d = enc_out;
                state_d   = RESP;
            end
            RESP: begin
                if (bus.rsp_ready[owner_q]) begin
                    rr_ptr_d = owner_next;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // No grant is advertised while reset is held, since nothing would be captured.
    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        case (state_q)
            IDLE:    if (n_rst) bus.req_ready = grant;
            RESP:    bus.rsp_valid[owner_q] = 1'b1;
            default: ;
        endcase
    end

    assign bus.rsp_data = out_reg_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_encryption_block_arbiter.sv
// Scoreboard bench for encryption_block_arbiter: expected AES round results are queued
// per requester when a request is driven and compared at each response handshake.
module tb_encryption_block_arbiter;
    import aes_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic n_rst = 1'b0;

    always #5 clk = ~clk;

    encryption_block_arbiter_if #(.N_REQ(N), .BLK_W(128)) bus ();

    encryption_block_arbiter #(.N_REQ(N), .BLK_W(128)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;
    aes_block_t expQ [N][$];
    int grantLog [$];

    function automatic aes_block_t fill(input logic [7:0] b);
        return {16{b}};
    endfunction

    // Drive a request and queue its expected result for the owning requester.
    task automatic applyStimulus(input int idx, input aes_block_t operand, input aes_block_t expected);
        bus.req_data[idx*128 +: 128] = operand;
        bus.req_valid[idx] = 1'b1;
        expQ[idx].push_back(expected);
    endtask

    task automatic doReset();
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        for (int i = 0; i < N; i++) expQ[i].delete();
    endtask

    // Run until nRsp response handshakes are seen, logging grants and dropping granted requests.
    task automatic checkOutput(input int nRsp, input int budget);
        int got;
        int cycles;
        int idx;
        logic [N-1:0] granted;
        aes_block_t expv;
        got = 0;
        cycles = 0;
        while (got < nRsp && cycles < budget) begin
            @(negedge clk);
            granted = bus.req_ready & bus.req_valid;
            for (int i = 0; i < N; i++) if (granted[i]) grantLog.push_back(i);
            if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
                checks++;
                if ($countones(bus.rsp_valid) != 1)
                    $display("[TB] FAIL rsp_onehot: got %b required one-hot", bus.rsp_valid);
                else passes++;
                idx = 0;
                for (int i = 0; i < N; i++) if (bus.rsp_valid[i]) idx = i;
                checks++;
                if (expQ[idx].size() == 0) begin
                    $display("[TB] FAIL rsp_unexpected: got response on requester %0d required none", idx);
                end else begin
                    expv = expQ[idx].pop_front();
                    if (bus.rsp_data !== expv)
                        $display("[TB] FAIL rsp_data[%0d]: got %h required %h", idx, bus.rsp_data, expv);
                    else passes++;
                end
                got++;
            end
            @(posedge clk);
            #1 bus.req_valid = bus.req_valid & ~granted;
            cycles++;
        end
        checks++;
        if (got !== nRsp)
            $display("[TB] FAIL rsp_count: got %0d responses required %0d within %0d cycles", got, nRsp, budget);
        else passes++;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0000) $display("[TB] FAIL reset_req_ready: got %b required 0000", bus.req_ready); else passes++;
        checks++; if (bus.rsp_valid !== 4'b0000) $display("[TB] FAIL reset_rsp_valid: got %b required 0000", bus.rsp_valid); else passes++;
        checks++; if (bus.rsp_data !== '0) $display("[TB] FAIL reset_rsp_data: got %h required 0", bus.rsp_data); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b required 0", bus.busy); else passes++;
        @(posedge clk);
        #1 n_rst = 1'b1;
    endtask

    task automatic test_single();
        bus.req_data[0 +: 128] = fill(8'h00);
        bus.req_valid[0] = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0001) $display("[TB] FAIL single_grant: got %b required 0001", bus.req_ready); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL single_busy_idle: got %b required 0", bus.busy); else passes++;
        @(posedge clk);
        #1 bus.req_valid[0] = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL single_busy_calc: got %b required 1", bus.busy); else passes++;
        checks++; if (bus.rsp_valid !== 4'b0000) $display("[TB] FAIL single_early_rsp: got %b required 0000", bus.rsp_valid); else passes++;
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 4'b0001) $display("[TB] FAIL single_rsp_valid: got %b required 0001", bus.rsp_valid); else passes++;
        checks++; if (bus.rsp_data !== fill(8'h63)) $display("[TB] FAIL single_rsp_data: got %h required %h", bus.rsp_data, fill(8'h63)); else passes++;
        checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL single_busy_resp: got %b required 1", bus.busy); else passes++;
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 4'b0000) $display("[TB] FAIL single_rsp_drop: got %b required 0000", bus.rsp_valid); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL single_busy_done: got %b required 0", bus.busy); else passes++;
        checks++; if (bus.rsp_data !== fill(8'h63)) $display("[TB] FAIL single_rsp_hold: got %h required %h", bus.rsp_data, fill(8'h63)); else passes++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_known_vector();
        applyStimulus(2, 128'hEAB09685AD455D652D339804F05C83C5, 128'h4C9F42BCA3703AA640D4E4A5741FAECC);
        checkOutput(1, 10);
    endtask

    task automatic test_back_to_back();
        logic [7:0] ops [4];
        logic [7:0] res [4];
        ops = '{8'h11, 8'h22, 8'h33, 8'h44};
        res = '{8'h82, 8'h93, 8'hc3, 8'h1b};
        doReset();
        grantLog.delete();
        for (int i = 0; i < N; i++) applyStimulus(i, fill(ops[i]), fill(res[i]));
        checkOutput(4, 40);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (i >= grantLog.size())
                $display("[TB] FAIL b2b_grant_order[%0d]: got no grant required %0d", i, i);
            else if (grantLog[i] != i)
                $display("[TB] FAIL b2b_grant_order[%0d]: got %0d required %0d", i, grantLog[i], i);
            else passes++;
        end
    endtask

    task automatic test_backpressure();
        bus.rsp_ready = 4'b1101;
        applyStimulus(1, fill(8'h55), fill(8'hfc));
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0010) $display("[TB] FAIL bp_grant: got %b required 0010", bus.req_ready); else passes++;
        @(posedge clk);
        #1 bus.req_valid[1] = 1'b0;
        applyStimulus(0, fill(8'h11), fill(8'h82));
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0000) $display("[TB] FAIL bp_calc_ready: got %b required 0000", bus.req_ready); else passes++;
        @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (bus.rsp_valid !== 4'b0010) $display("[TB] FAIL bp_rsp_valid[%0d]: got %b required 0010", c, bus.rsp_valid); else passes++;
            checks++; if (bus.rsp_data !== fill(8'hfc)) $display("[TB] FAIL bp_rsp_data[%0d]: got %h required %h", c, bus.rsp_data, fill(8'hfc)); else passes++;
            checks++; if (bus.req_ready !== 4'b0000) $display("[TB] FAIL bp_req_ready[%0d]: got %b required 0000", c, bus.req_ready); else passes++;
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = '1;
        grantLog.delete();
        checkOutput(2, 20);
        checks++;
        if (grantLog.size() != 1 || grantLog[0] != 0)
            $display("[TB] FAIL bp_next_grant: got %0d grants required one grant to requester 0", grantLog.size());
        else passes++;
    endtask

    task automatic test_wraparound();
        grantLog.delete();
        applyStimulus(3, fill(8'h44), fill(8'h1b));
        checkOutput(1, 10);
        checks++;
        if (grantLog.size() != 1 || grantLog[0] != 3)
            $display("[TB] FAIL wrap_last_grant: got %0d grants required one grant to requester 3", grantLog.size());
        else passes++;
        grantLog.delete();
        applyStimulus(3, fill(8'h33), fill(8'hc3));
        applyStimulus(0, fill(8'h22), fill(8'h93));
        checkOutput(2, 20);
        checks++;
        if (grantLog.size() != 2 || grantLog[0] != 0 || grantLog[1] != 3)
            $display("[TB] FAIL wrap_order: got %0d grants (first %0d) required 0 then 3", grantLog.size(), grantLog.size() > 0 ? grantLog[0] : -1);
        else passes++;
    endtask

    task automatic test_reset_in_calc();
        logic seenRsp;
        bus.req_data[2*128 +: 128] = fill(8'h00);
        bus.req_valid[2] = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0100) $display("[TB] FAIL rcalc_grant: got %b required 0100", bus.req_ready); else passes++;
        @(posedge clk);
        #1 bus.req_valid[2] = 1'b0;
        n_rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0000) $display("[TB] FAIL rcalc_req_ready: got %b required 0000", bus.req_ready); else passes++;
        checks++; if (bus.rsp_valid !== 4'b0000) $display("[TB] FAIL rcalc_rsp_valid: got %b required 0000", bus.rsp_valid); else passes++;
        checks++; if (bus.rsp_data !== '0) $display("[TB] FAIL rcalc_rsp_data: got %h required 0", bus.rsp_data); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL rcalc_busy: got %b required 0", bus.busy); else passes++;
        n_rst = 1'b1;
        seenRsp = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0) seenRsp = 1'b1;
        end
        checks++; if (seenRsp !== 1'b0) $display("[TB] FAIL rcalc_aborted_rsp: got activity required none"); else passes++;
        @(posedge clk);
        #1;
        applyStimulus(1, fill(8'h22), fill(8'h93));
        checkOutput(1, 10);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = '1;
        test_reset();
        test_single();
        test_known_vector();
        test_back_to_back();
        test_backpressure();
        test_wraparound();
        test_reset_in_calc();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
